// File: rtl/fwrisc_tracer_pkg.sv
// fwrisc_tracer_pkg: shared trace event types and age comparison for the trace arbiter
package fwrisc_tracer_pkg;
  localparam int TRACE_TIME_W = 16;
  typedef enum logic [1:0] {EV_EXEC, EV_REG, EV_MEM} ev_kind_e;
  typedef struct packed {
    ev_kind_e                kind;
    logic [TRACE_TIME_W-1:0] tstamp;
    logic [31:0]             addr;
    logic [31:0]             data;
    logic [4:0]              aux;
  } trace_ev_t;
  // Modular age test: a is older than b when the wrapped difference is negative
  function automatic logic older(input logic [TRACE_TIME_W-1:0] a, input logic [TRACE_TIME_W-1:0] b);
    logic [TRACE_TIME_W-1:0] d;
    d = a - b;
    return d[TRACE_TIME_W-1];
  endfunction
endpackage

// File: rtl/fwrisc_tracer_fifo.sv
// fwrisc_tracer_fifo: synchronous FIFO of trace events
// Ports: clock/reset (async active-high), push/din write side, pop/head read side,
//        full/empty status. A push while full is dropped even if a pop happens on the same edge.
module fwrisc_tracer_fifo
  import fwrisc_tracer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  trace_ev_t din,
  input  logic      pop,
  output trace_ev_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  trace_ev_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rp];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/fwrisc_tracer_arb.sv
// fwrisc_tracer_arb: merges exec/reg/mem trace events onto one valid/ready port, oldest first
// Ports: clock, reset (async active-high); exec tap ivalid/addr/instr; reg tap rwrite/raddr/rdata;
//        mem tap mvalid/maddr/mdata/mstrb/mwrite; output ev_valid/ev_ready/ev_kind/ev_time/
//        ev_addr/ev_data/ev_aux; sticky overflow[2:0] = {MEM,REG,EXEC}.
//        FWRISC_TRACER_ARB_DROP_CNT_EN adds drop_count[15:0], a saturating total of dropped events.
module fwrisc_tracer_arb
  import fwrisc_tracer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ivalid,
  input  logic [31:0] addr,
  input  logic [31:0] instr,
  input  logic        rwrite,
  input  logic [31:0] raddr,
  input  logic [31:0] rdata,
  input  logic        mvalid,
  input  logic [31:0] maddr,
  input  logic [31:0] mdata,
  input  logic [3:0]  mstrb,
  input  logic        mwrite,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [1:0]  ev_kind,
  output logic [15:0] ev_time,
  output logic [31:0] ev_addr,
  output logic [31:0] ev_data,
  output logic [4:0]  ev_aux,
  output logic [2:0]  overflow
`ifdef FWRISC_TRACER_ARB_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);
  typedef enum logic {EMPTY, HOLD} state_e;
  state_e state, nxt;
  logic [TRACE_TIME_W-1:0] ts;
  trace_ev_t in_ev [3];
  trace_ev_t head [3];
  trace_ev_t winner, ev;
  logic [2:0] push, pop, full, empty, avail, drop;
  logic sel_x, sel_r, sel_m, any, load;
  assign push = {mvalid, rwrite, ivalid};
  assign avail = ~empty;
  assign drop = push & full;
  always_comb begin
    in_ev[0] = '{kind: EV_EXEC, tstamp: ts, addr: addr, data: instr, aux: 5'd0};
    in_ev[1] = '{kind: EV_REG, tstamp: ts, addr: raddr, data: rdata, aux: 5'd0};
    in_ev[2] = '{kind: EV_MEM, tstamp: ts, addr: maddr, data: mdata, aux: {mwrite, mstrb}};
  end
  for (genvar i = 0; i < 3; i++) begin : g_fifo
    fwrisc_tracer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock(clock), .reset(reset), .push(push[i]), .din(in_ev[i]),
      .pop(pop[i]), .head(head[i]), .full(full[i]), .empty(empty[i])
    );
  end
  // A younger-or-equal rival never beats an earlier source, giving EXEC > REG > MEM on ties
  always_comb begin
    sel_x = avail[0] && !(avail[1] && older(head[1].tstamp, head[0].tstamp))
                     && !(avail[2] && older(head[2].tstamp, head[0].tstamp));
    sel_r = !sel_x && avail[1] && !(avail[2] && older(head[2].tstamp, head[1].tstamp));
    sel_m = !sel_x && !sel_r && avail[2];
    any = |avail;
    winner = sel_x ? head[0] : sel_r ? head[1] : head[2];
    load = state == EMPTY || ev_ready;
    nxt = load ? (any ? HOLD : EMPTY) : state;
    pop = load ? {sel_m, sel_r, sel_x} : 3'b000;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      ev <= '0;
      ts <= '0;
      overflow <= '0;
    end else begin
      state <= nxt;
      if (load && any) ev <= winner;
      ts <= ts + 1'b1;
      overflow <= overflow | drop;
    end
  end
`ifdef FWRISC_TRACER_ARB_DROP_CNT_EN
  logic [16:0] dsum;
  assign dsum = {1'b0, drop_count} + 17'(drop[0]) + 17'(drop[1]) + 17'(drop[2]);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_count <= '0;
    else drop_count <= dsum[16] ? 16'hFFFF : dsum[15:0];
  end
`endif
  assign ev_valid = state == HOLD;
  assign ev_kind = ev.kind;
  assign ev_time = ev.tstamp;
  assign ev_addr = ev.addr;
  assign ev_data = ev.data;
  assign ev_aux = ev.aux;
endmodule

// File: tb/tb_fwrisc_tracer_arb.sv
// tb_fwrisc_tracer_arb: scoreboard bench for the trace arbiter
module tb_fwrisc_tracer_arb;
  logic clock, reset;
  logic ivalid, rwrite, mvalid, mwrite, ev_ready, ev_valid;
  logic [31:0] addr, instr, raddr, rdata, maddr, mdata, ev_addr, ev_data;
  logic [3:0] mstrb;
  logic [1:0] ev_kind;
  logic [15:0] ev_time, ts_m;
  logic [4:0] ev_aux;
  logic [2:0] overflow;
`ifdef FWRISC_TRACER_ARB_DROP_CNT_EN
  logic [15:0] drop_count;
`endif
  logic [86:0] exp_q [$];
  int total = 0;
  int bad = 0;

  fwrisc_tracer_arb #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .ivalid(ivalid), .addr(addr), .instr(instr),
    .rwrite(rwrite), .raddr(raddr), .rdata(rdata),
    .mvalid(mvalid), .maddr(maddr), .mdata(mdata), .mstrb(mstrb), .mwrite(mwrite),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_time(ev_time),
    .ev_addr(ev_addr), .ev_data(ev_data), .ev_aux(ev_aux), .overflow(overflow)
`ifdef FWRISC_TRACER_ARB_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // reference timestamp: value seen by the next capturing edge
  always @(posedge clock or posedge reset) begin
    if (reset) ts_m <= 16'd0;
    else ts_m <= ts_m + 16'd1;
  end

  // scoreboard: every accepted event must match the oldest expected one
  always @(negedge clock) begin
    if (!reset && ev_valid && ev_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard unexpected event got=%h", {ev_kind, ev_time, ev_addr, ev_data, ev_aux});
      end else begin
        logic [86:0] e;
        e = exp_q.pop_front();
        if ({ev_kind, ev_time, ev_addr, ev_data, ev_aux} !== e) begin
          bad++;
          $display("FAIL scoreboard got=%h exp=%h", {ev_kind, ev_time, ev_addr, ev_data, ev_aux}, e);
        end
      end
    end
  end

  // called just after a posedge; the following posedge captures the event
  task automatic drive(input bit x, input bit r, input bit m, input bit exp_en,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] st, input bit w);
    ivalid = x; addr = a; instr = d;
    rwrite = r; raddr = a + 32'd4; rdata = d ^ 32'h0000FFFF;
    mvalid = m; maddr = a + 32'd8; mdata = ~d; mstrb = st; mwrite = w;
    if (exp_en) begin
      if (x) exp_q.push_back({2'd0, ts_m, a, d, 5'd0});
      if (r) exp_q.push_back({2'd1, ts_m, a + 32'd4, d ^ 32'h0000FFFF, 5'd0});
      if (m) exp_q.push_back({2'd2, ts_m, a + 32'd8, ~d, {w, st}});
    end
    @(posedge clock); #1;
    ivalid = 0; rwrite = 0; mvalid = 0;
  endtask

  task automatic wait_ts(input logic [15:0] target);
    int n = 0;
    while (ts_m !== target && n < 70000) begin
      @(posedge clock); #1;
      n++;
    end
    total++;
    if (ts_m !== target) begin
      bad++;
      $display("FAIL wait_ts got=%h exp=%h", ts_m, target);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    total++;
    if (exp_q.size() != 0 || ev_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s drain left=%0d ev_valid=%b exp left=0 ev_valid=0", name, exp_q.size(), ev_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({ev_valid, ev_kind, ev_time, ev_addr, ev_data, ev_aux, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {ev_valid, ev_kind, ev_time, ev_addr, ev_data, ev_aux, overflow});
    end
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic test_single();
    ev_ready = 1;
    wait_ts(16'd10);
    drive(1, 0, 0, 1, 32'h80000000, 32'h00000013, 4'h0, 0);
    total++;
    if (ev_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_latency ev_valid got=%b exp=0", ev_valid);
    end
    @(posedge clock); #1;
    total++;
    if ({ev_valid, ev_kind, ev_time} !== {1'b1, 2'd0, 16'd10}) begin
      bad++;
      $display("FAIL single_out got=%b/%0d/%0d exp=1/0/10", ev_valid, ev_kind, ev_time);
    end
    @(posedge clock); #1;
    total++;
    if (ev_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_after ev_valid got=%b exp=0", ev_valid);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 1, 1, 32'h00000FF8, 32'hCAFE0001, 4'hF, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      total++;
      if ({ev_valid, ev_kind} !== {1'b1, 2'(i)}) begin
        bad++;
        $display("FAIL b2b_slot%0d got=%b/%0d exp=1/%0d", i, ev_valid, ev_kind, i);
      end
    end
    drain("b2b");
  endtask

  task automatic test_overflow();
    ev_ready = 0;
    for (int i = 0; i < 6; i++)
      drive(1, 0, 0, i < 5, 32'h100 + 32'(i), 32'hA0 + 32'(i), 4'h0, 0);
    total++;
    if ({ev_valid, ev_addr} !== {1'b1, 32'h100}) begin
      bad++;
      $display("FAIL overflow_hold got=%b/%h exp=1/00000100", ev_valid, ev_addr);
    end
    total++;
    if (overflow !== 3'b001) begin
      bad++;
      $display("FAIL overflow_flag got=%b exp=001", overflow);
    end
`ifdef FWRISC_TRACER_ARB_DROP_CNT_EN
    total++;
    if (drop_count !== 16'd1) begin
      bad++;
      $display("FAIL drop_count got=%0d exp=1", drop_count);
    end
`endif
    ev_ready = 1;
    drain("overflow");
  endtask

  task automatic test_age_order();
    ev_ready = 0;
    drive(1, 0, 0, 1, 32'h200, 32'h1, 4'h0, 0);
    drive(0, 1, 0, 1, 32'h300, 32'h2, 4'h0, 0);
    @(posedge clock); #1;
    drive(1, 0, 0, 1, 32'h400, 32'h3, 4'h0, 0);
    ev_ready = 1;
    drain("age_order");
  endtask

  task automatic test_mid_reset();
    ev_ready = 0;
    drive(1, 1, 1, 0, 32'h500, 32'h5, 4'h3, 0);
    drive(1, 0, 1, 0, 32'h600, 32'h6, 4'h1, 1);
    @(negedge clock);
    total++;
    if (ev_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_pre ev_valid got=%b exp=1", ev_valid);
    end
    reset = 1;
    #1;
    total++;
    if ({ev_valid, ev_kind, ev_time, ev_addr, ev_data, ev_aux, overflow} !== '0) begin
      bad++;
      $display("FAIL mid_reset_async got=%h exp=0", {ev_valid, ev_kind, ev_time, ev_addr, ev_data, ev_aux, overflow});
    end
    @(posedge clock); #1;
    reset = 0;
    ev_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      total++;
      if (ev_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_stale cycle%0d ev_valid got=%b exp=0", i, ev_valid);
      end
    end
  endtask

  task automatic test_wrap();
    ev_ready = 0;
    wait_ts(16'hFFFC);
    drive(0, 1, 0, 1, 32'h700, 32'h7, 4'h0, 0);
    wait_ts(16'hFFFE);
    drive(0, 0, 1, 1, 32'h800, 32'h8, 4'h6, 0);
    wait_ts(16'h0001);
    drive(1, 0, 0, 1, 32'h900, 32'h9, 4'h0, 0);
    ev_ready = 1;
    drain("wrap");
  endtask

  initial begin
    reset = 1; ev_ready = 0;
    ivalid = 0; rwrite = 0; mvalid = 0; mwrite = 0; mstrb = 0;
    addr = 0; instr = 0; raddr = 0; rdata = 0; maddr = 0; mdata = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_age_order();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
